// File: rtl/cpu_defs.sv
// Shared core definitions: shift encodings, datapath widths and the
// state type of the shift arbiter.
package cpu_defs;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic [1:0] SHIFT_LL = 2'b00;
    localparam logic [1:0] SHIFT_LR = 2'b01;
    localparam logic [1:0] SHIFT_AL = 2'b10;
    localparam logic [1:0] SHIFT_AR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } arb_state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: logical/arithmetic left and right.
module shift_core
    import cpu_defs::*;
(
    input  logic [1:0]        i_way,
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        unique case (i_way)
            SHIFT_LL, SHIFT_AL: o_data = i_data << i_amt;
            SHIFT_LR:           o_data = i_data >> i_amt;
            SHIFT_AR:           o_data = DATA_W'($signed(i_data) >>> i_amt);
            default:            o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core among NUM_REQ requesters,
// with a registered, id-tagged result behind a valid/ready handshake.
module shift_arbiter
    import cpu_defs::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_way,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [AMT_W*NUM_REQ-1:0] req_amt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ID_W-1:0]          rsp_id
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;

    logic                w_found;
    logic                w_grant;
    logic                w_can_accept;
    logic [ID_W-1:0]     w_gidx;
    logic [1:0]          w_way;
    logic [DATA_W-1:0]   w_data;
    logic [AMT_W-1:0]    w_amt;
    logic [DATA_W-1:0]   w_result;

    // Search from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        w_way   = '0;
        w_data  = '0;
        w_amt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'(v_idx);
                w_way   = req_way[2*v_idx +: 2];
                w_data  = req_data[DATA_W*v_idx +: DATA_W];
                w_amt   = req_amt[AMT_W*v_idx +: AMT_W];
            end
        end
    end

    assign w_can_accept = (r_state == ST_IDLE) || rsp_ready;
    assign w_grant      = rst_n && w_found && w_can_accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant && (w_gidx == ID_W'(i));
        end
    end

    shift_core u_shift_core (
        .i_way  (w_way),
        .i_data (w_data),
        .i_amt  (w_amt),
        .o_data (w_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL: if (rsp_ready && !w_grant) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= w_gidx;
                r_rr_ptr   <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0
                                                           : w_gidx + ID_W'(1);
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter (3 requesters)
// against a transaction-level reference model.
module tb_shift_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_way = '0;
    logic [32*N-1:0] req_data = '0;
    logic [5*N-1:0]  req_amt = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_data;
    logic [IW-1:0]   rsp_id;

    always #5 clk = ~clk;

    shift_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_way   (req_way),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: result slot, rotating priority pointer, pending grant
    int          m_ptr = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_id = 0;
    int          m_gnt = -1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input int way,
                                              input logic [31:0] d,
                                              input int amt);
        longint unsigned v, p, x, top;
        x   = {32'd0, d};
        p   = 64'd1 << amt;
        top = 64'd1 << 32;
        case (way)
            0, 2:    v = (x * p) % top;
            1:       v = x / p;
            default: begin
                v = x / p;
                if (d[31]) v = v + (top - top / p);
            end
        endcase
        return v[31:0];
    endfunction

    task automatic predict();
        m_gnt = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_gnt < 0 && req_valid[idx]) m_gnt = idx;
            end
        end
    endtask

    task automatic commit();
        if (m_gnt >= 0) begin
            m_valid = 1'b1;
            m_data  = ref_shift(int'(req_way[2*m_gnt +: 2]),
                                req_data[32*m_gnt +: 32],
                                int'(req_amt[5*m_gnt +: 5]));
            m_id    = m_gnt;
            m_ptr   = (m_gnt + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_rdy;
        #1;
        predict();
        exp_rdy = '0;
        if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
        check("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        check("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] w,
                           input logic [31:0] d, input logic [4:0] a);
        req_valid[i]         = 1'b1;
        req_way[2*i +: 2]    = w;
        req_data[32*i +: 32] = d;
        req_amt[5*i +: 5]    = a;
    endtask

    logic [31:0] mode_exp [4] = '{32'h0000_0002, 32'h4000_0000,
                                  32'h0000_0002, 32'hC000_0000};

    initial begin
        // reset holds everything quiet, even with a request present
        req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // single arithmetic-right op, 1-cycle latency
        rsp_ready = 1'b1;
        set_req(0, 2'b11, 32'h8000_0000, 5'd4);
        tick();
        req_valid = '0;
        check("single_valid", rsp_valid, 1);
        check("single_data", rsp_data, 32'hF800_0000);
        check("single_id", rsp_id, 0);
        tick();

        // all four modes
        for (int w = 0; w < 4; w++) begin
            set_req(0, 2'(w), 32'h8000_0001, 5'd1);
            tick();
            req_valid = '0;
            check("mode_data", rsp_data, mode_exp[w]);
            tick();
        end

        // async reset while a result is held
        rsp_ready = 1'b0;
        set_req(2, 2'b00, 32'h1234_5678, 5'd3);
        tick();
        check("pre_rst_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_data", rsp_data, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_ready", req_ready, 0);
        m_valid = 1'b0;
        m_ptr   = 0;
        m_gnt   = -1;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;

        // fairness: 0 and 1 both valid, back-to-back results
        rsp_ready = 1'b1;
        set_req(0, 2'b01, 32'hF0F0_0000, 5'd8);
        set_req(1, 2'b10, 32'h0000_0F0F, 5'd12);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("fair_valid", rsp_valid, 1);
            check("fair_id", rsp_id, k % 2);
        end

        // backpressure: result frozen, no grants
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_data", rsp_data, ref_shift(2, 32'h0000_0F0F, 12));
            check("bp_id", rsp_id, 1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_id", rsp_id, 0);
        check("bp_release_data", rsp_data, 32'h00F0_F000);

        // boundary amounts
        req_valid = '0;
        set_req(0, 2'b11, 32'hA5C3_3C5A, 5'd0);
        tick();
        check("amt0", rsp_data, 32'hA5C3_3C5A);
        set_req(0, 2'b11, 32'h8000_0000, 5'd31);
        tick();
        check("amt31_ar", rsp_data, 32'hFFFF_FFFF);

        // pointer wrap 2 -> 0
        req_valid = '0;
        set_req(1, 2'b00, 32'h1, 5'd1);
        tick();
        check("wrap_g1", rsp_id, 1);
        set_req(0, 2'b00, 32'h1, 5'd2);
        set_req(2, 2'b00, 32'h1, 5'd3);
        tick();
        check("wrap_g2", rsp_id, 2);
        check("wrap_g2_data", rsp_data, 32'h8);
        tick();
        check("wrap_g0", rsp_id, 0);
        check("wrap_g0_data", rsp_data, 32'h4);
        req_valid = '0;
        tick();

        // random traffic; a request keeps its payload until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_gnt == i) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 2'($urandom), $urandom,
                                5'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
